uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Byte-stream UART transmitter feeding the board-level `tx_data` pin of `FPGA_top`. It takes result bytes from the core datapath through a valid/ready handshake and buffers them in a small FIFO. It serialises them as 8N1 frames (LSB first), so the datapath is never stalled for a whole frame. The output is line-idle-high and runs continuously back-to-back while the buffer holds data.

## Interface
- `CLK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- `FIFO_DEPTH`, default 16: byte buffer depth. Must be a power of 2 and at least 2.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ/BAUD`, integer division. It is 868 at the defaults and must be at least 2.
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `data_i`, input, 8: byte to send. Sampled when `valid_i && ready_o`.
- `valid_i`, input, 1: upstream byte valid.
- `ready_o`, output, 1: buffer can accept a byte. Equals `!full`.
- `tx_data`, output, 1: serial line. Registered output, idle = 1.
- `busy_o`, output, 1: a frame is in flight, or the FIFO is non-empty.
- `fifo_count_o`, output, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- **Reset values** (while `rst` is asserted):
  - `tx_data=1`, `busy_o=0`, `fifo_count_o=0`, `ready_o=1`.
  - FSM is in IDLE, FIFO pointers are 0, and the bit/baud counters are 0.
- **Push:** on an edge where `valid_i && ready_o`, `data_i` is written to the FIFO tail.
  - While full, `valid_i` is ignored.
  - No data is lost or overwritten.
- **FSM states and transitions:**
  - IDLE → START: when the FIFO is non-empty, pop the head into the 8-bit shift register and clear the baud counter.
  - START: `tx_data=0` for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx_data=shift[0]` for `CLKS_PER_BIT` cycles per bit, then shift right.
    - Increment the index after each bit.
    - After index 7 completes, go to STOP.
  - STOP: `tx_data=1` for `CLKS_PER_BIT` cycles.
    - On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- **Counters:**
  - The baud counter counts 0..`CLKS_PER_BIT-1` and wraps.
  - The bit index is 3 bits and counts 0..7.
  - FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - Occupancy is one bit wider than the pointers.
- **Simultaneous push and pop:**
  - When not full, both happen and the count is unchanged.
  - When full, the push is refused; `ready_o` is not a pop-through.
- **Reset mid-frame:** the frame is aborted and the FIFO contents are discarded. `tx_data` returns to 1 asynchronously.

## Timing
- **Start latency:** a byte is pushed into an empty, idle block at edge k.
  - The FIFO pop and START entry happen at edge k+1.
  - `tx_data` falls after edge k+1.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles, from the falling edge of the start bit to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **`ready_o`:** deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the next pop.
- **`busy_o`:** rises one cycle after the first push. It falls on the first IDLE cycle with the FIFO empty.
- **`fifo_count_o`:** updated on the same edge as the push or pop.

## Structure
- **Package `uart_pkg`:**
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t`.
  - Constants `UART_DATA_BITS=8` and `UART_IDLE_LEVEL=1'b1`.
- **Sub-module `sync_fifo`:**
  - Parameters: width 8, `FIFO_DEPTH`.
  - Ports: `clk`, `rst`, push/pop, full/empty, and count.
  - Reusable for a future `uart_rx_stream`.
- **Top:** `uart_tx_stream` contains the FSM, the baud counter, the bit index, the shift register and the output register.

## Test plan
All scenarios use `CLK_FREQ=1000` and `BAUD=100`, giving `CLKS_PER_BIT=10`, with `FIFO_DEPTH=4` unless stated otherwise.
- **Reset:** hold `rst` for 20 cycles.
  - During reset: `tx_data=1`, `busy_o=0`, `fifo_count_o=0`, `ready_o=1`.
  - The line stays 1 for 100 idle cycles after release.
- **Single byte 0x55:** push one byte.
  - `tx_data` falls one cycle after the push.
  - Sampling mid-bit gives 0,1,0,1,0,1,0,1,0,1 at 10-cycle spacing.
  - `busy_o` clears 100 cycles after the start bit.
- **Back-to-back 0xA3, 0x0F:** push both bytes on consecutive cycles.
  - The frames are contiguous with no idle cycle: 200 cycles total.
  - The decoded bytes match.
- **Full FIFO:** hold `valid_i` high with bytes 0x01..0x06.
  - One byte is popped immediately, so the FIFO holds 4 and one byte sits in the shifter.
  - `ready_o=0` after 5 bytes are accepted.
  - 0x06 is held until `ready_o` returns.
  - All 6 bytes arrive in order.
- **Push during pop:** push in the same cycle as the STOP→START pop.
  - `fifo_count_o` is unchanged.
  - The byte is transmitted in sequence.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 2 bytes queued.
  - `tx_data=1` immediately and `fifo_count_o=0`.
  - No frame follows after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-stream UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 32'd8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Counter width that still works when the terminal count is 1.
  function automatic int cnt_width(input int n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32'd8,
  parameter int DEPTH = 32'd16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full buffer is dropped here so no entry is ever overwritten.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Storage array, written at the tail pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, FIFO, serialiser.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 32'd100_000_000,
  parameter int BAUD       = 32'd115200,
  parameter int FIFO_DEPTH = 32'd16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_data,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = cnt_width(CLKS_PER_BIT);

  uart_tx_state_t            state_r;
  uart_tx_state_t            next_state_s;
  logic [BW-1:0]             baud_cnt_r;
  logic [2:0]                bit_idx_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [UART_DATA_BITS-1:0] shift_next_s;
  logic                      tx_r;
  logic                      tx_next_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [7:0]                fifo_rdata_s;
  logic                      baud_last_s;
  logic                      bit_last_s;

  assign push_s       = valid_i && !fifo_full_s;
  assign ready_o      = !fifo_full_s;
  assign busy_o       = (state_r != IDLE) || !fifo_empty_s;
  assign tx_data      = tx_r;
  assign baud_last_s  = (baud_cnt_r == BW'(CLKS_PER_BIT - 32'd1));
  assign bit_last_s   = (bit_idx_r == 3'(UART_DATA_BITS - 32'd1));

  sync_fifo #(
    .WIDTH (32'd8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (data_i),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_o)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and FIFO pop; the STOP exit pops directly so frames abut.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          next_state_s = START;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (baud_last_s) next_state_s = DATA;
        else             next_state_s = START;
      end
      DATA: begin
        if (baud_last_s && bit_last_s) next_state_s = STOP;
        else                           next_state_s = DATA;
      end
      STOP: begin
        if (baud_last_s) begin
          if (!fifo_empty_s) begin
            next_state_s = START;
            pop_s        = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = STOP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Line level is derived from the next state so the registered pin changes on the transition edge.
  always_comb begin
    shift_next_s = shift_r;
    tx_next_s    = UART_IDLE_LEVEL;
    if (pop_s) begin
      shift_next_s = fifo_rdata_s;
    end else if ((state_r == DATA) && baud_last_s) begin
      shift_next_s = shift_r >> 1;
    end else begin
      shift_next_s = shift_r;
    end
    case (next_state_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      STOP:    tx_next_s = UART_IDLE_LEVEL;
      IDLE:    tx_next_s = UART_IDLE_LEVEL;
      default: tx_next_s = UART_IDLE_LEVEL;
    endcase
  end

  // Baud counter, bit index, shift register and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_r <= {BW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= {UART_DATA_BITS{1'b0}};
      tx_r       <= UART_IDLE_LEVEL;
    end else begin
      if (pop_s || (state_r == IDLE) || baud_last_s) begin
        baud_cnt_r <= {BW{1'b0}};
      end else begin
        baud_cnt_r <= baud_cnt_r + BW'(1);
      end
      if (state_r == START) begin
        bit_idx_r <= 3'd0;
      end else if ((state_r == DATA) && baud_last_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      shift_r <= shift_next_s;
      tx_r    <= tx_next_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at 10 clocks per bit with a 4-deep FIFO.
module tb_uart_tx_stream;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx_data;
  logic       busy_o;
  logic [2:0] fifo_count_o;

  int total = 0;
  int bad   = 0;
  logic       mon_en = 1'b0;
  logic [9:0] rx_q[$];

  uart_tx_stream #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .tx_data      (tx_data),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: samples each bit mid-cell, stores {stop, data, start}; frames hit by reset are dropped.
  initial begin
    logic [9:0] bits;
    logic       ab;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst && tx_data === 1'b0) begin
        ab   = 1'b0;
        bits = '0;
        for (int c = 0; c < 99; c++) begin
          @(posedge clk);
          #1;
          if (rst) ab = 1'b1;
          if (c % 10 == 4) bits[c/10] = tx_data;
        end
        if (!ab) rx_q.push_back(bits);
      end
    end
  end

  task automatic test_reset();
    int lows;
    rst = 1'b1; valid_i = 1'b0; data_i = 8'h00;
    repeat (20) tick();
    total++; if (tx_data !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_data); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (fifo_count_o !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    rst = 1'b0;
    lows = 0;
    repeat (100) begin tick(); if (tx_data !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL idle_line: got %0d low cycles want 0", lows); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_single();
    logic [9:0] got;
    rx_q.delete();
    data_i = 8'h55; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    total++; if (tx_data !== 1'b1) begin bad++; $display("FAIL single_pre_tx: got %b want 1", tx_data); end
    total++; if (fifo_count_o !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy_rise: got %b want 1", busy_o); end
    tick();
    total++; if (tx_data !== 1'b0) begin bad++; $display("FAIL single_start: got %b want 0", tx_data); end
    total++; if (fifo_count_o !== 3'd0) begin bad++; $display("FAIL single_pop: got %0d want 0", fifo_count_o); end
    repeat (99) tick();
    total++; if (busy_o !== 1'b1 || tx_data !== 1'b1) begin bad++; $display("FAIL single_stop: got busy=%b tx=%b want 1 1", busy_o, tx_data); end
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b want 0", busy_o); end
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 10'bx;
    total++; if (got !== 10'b1010101010) begin bad++; $display("FAIL single_frame: got %b want 1010101010", got); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [9:0] got;
    rx_q.delete();
    valid_i = 1'b1; data_i = 8'hA3;
    tick();
    data_i = 8'h0F;
    tick();
    valid_i = 1'b0;
    total++; if (tx_data !== 1'b0) begin bad++; $display("FAIL b2b_start: got %b want 0", tx_data); end
    repeat (100) tick();
    total++; if (tx_data !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", tx_data); end
    n = 100;
    while (busy_o && n < 400) begin tick(); n++; end
    total++; if (n != 200) begin bad++; $display("FAIL b2b_length: got %0d want 200", n); end
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 10'bx;
    total++; if (got !== {1'b1, 8'hA3, 1'b0}) begin bad++; $display("FAIL b2b_frame0: got %b want %b", got, {1'b1, 8'hA3, 1'b0}); end
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 10'bx;
    total++; if (got !== {1'b1, 8'h0F, 1'b0}) begin bad++; $display("FAIL b2b_frame1: got %b want %b", got, {1'b1, 8'h0F, 1'b0}); end
  endtask

  task automatic test_full_fifo();
    int idx;
    int w;
    logic acc;
    logic [9:0] got;
    rx_q.delete();
    idx = 0;
    valid_i = 1'b1;
    for (int n = 0; n < 50 && idx < 5; n++) begin
      data_i = 8'(idx + 1);
      acc = ready_o;
      tick();
      if (acc) idx++;
    end
    total++; if (idx != 5) begin bad++; $display("FAIL full_accepted: got %0d want 5", idx); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", ready_o); end
    total++; if (fifo_count_o !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", fifo_count_o); end
    data_i = 8'h06;
    w = 0;
    while (!ready_o && w < 300) begin tick(); w++; end
    total++; if (w != 97) begin bad++; $display("FAIL full_ready_return: got %0d cycles want 97", w); end
    total++; if (fifo_count_o !== 3'd3) begin bad++; $display("FAIL full_after_pop: got %0d want 3", fifo_count_o); end
    tick();
    valid_i = 1'b0;
    total++; if (fifo_count_o !== 3'd4) begin bad++; $display("FAIL full_push6: got %0d want 4", fifo_count_o); end
    w = 0;
    while (rx_q.size() < 6 && w < 700) begin tick(); w++; end
    total++; if (rx_q.size() != 6) begin bad++; $display("FAIL full_frames: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 10'bx;
      total++; if (got !== {1'b1, 8'(i + 1), 1'b0}) begin bad++; $display("FAIL full_order%0d: got %b want %b", i, got, {1'b1, 8'(i + 1), 1'b0}); end
    end
  endtask

  task automatic test_push_during_pop();
    int w;
    logic [9:0] got;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h3C; exp_b[1] = 8'hC5; exp_b[2] = 8'h96;
    rx_q.delete();
    valid_i = 1'b1; data_i = exp_b[0];
    tick();
    data_i = exp_b[1];
    tick();
    valid_i = 1'b0;
    repeat (99) tick();
    total++; if (fifo_count_o !== 3'd1) begin bad++; $display("FAIL pdp_before: got %0d want 1", fifo_count_o); end
    valid_i = 1'b1; data_i = exp_b[2];
    tick();
    valid_i = 1'b0;
    total++; if (fifo_count_o !== 3'd1) begin bad++; $display("FAIL pdp_after: got %0d want 1", fifo_count_o); end
    total++; if (tx_data !== 1'b0) begin bad++; $display("FAIL pdp_start: got %b want 0", tx_data); end
    w = 0;
    while (rx_q.size() < 3 && w < 400) begin tick(); w++; end
    for (int i = 0; i < 3; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 10'bx;
      total++; if (got !== {1'b1, exp_b[i], 1'b0}) begin bad++; $display("FAIL pdp_frame%0d: got %b want %b", i, got, {1'b1, exp_b[i], 1'b0}); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    int busy_cyc;
    rx_q.delete();
    valid_i = 1'b1; data_i = 8'h00;
    tick();
    data_i = 8'h11;
    tick();
    data_i = 8'h22;
    tick();
    valid_i = 1'b0;
    repeat (44) tick();
    total++; if (tx_data !== 1'b0 || fifo_count_o !== 3'd2) begin bad++; $display("FAIL rmf_pre: got tx=%b count=%0d want 0 2", tx_data, fifo_count_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (tx_data !== 1'b1) begin bad++; $display("FAIL rmf_tx: got %b want 1", tx_data); end
    total++; if (fifo_count_o !== 3'd0) begin bad++; $display("FAIL rmf_count: got %0d want 0", fifo_count_o); end
    total++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL rmf_flags: got busy=%b ready=%b want 0 1", busy_o, ready_o); end
    repeat (3) tick();
    rst = 1'b0;
    lows = 0; busy_cyc = 0;
    repeat (150) begin
      tick();
      if (tx_data !== 1'b1) lows++;
      if (busy_o !== 1'b0) busy_cyc++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL rmf_line: got %0d low cycles want 0", lows); end
    total++; if (busy_cyc != 0) begin bad++; $display("FAIL rmf_busy: got %0d busy cycles want 0", busy_cyc); end
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rmf_frames: got %0d want 0", rx_q.size()); end
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_single();
    repeat (5) tick();
    test_back_to_back();
    repeat (5) tick();
    test_full_fifo();
    repeat (5) tick();
    test_push_during_pop();
    repeat (5) tick();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
